// File: rtl/bar_color_sched_pkg.sv
// Shared types and constants for the bar-colour table sequencer.
package bar_color_sched_pkg;

  localparam int RGB_W = 15;
  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/bar_color_sched.sv
// Time-shares one BarColor engine between a full two-channel table refresh and
// single-entry updates; results land in the bar-colour RAM at {ch,bar}.
module bar_color_sched
  import bar_color_sched_pkg::*;
#(
  parameter int BAR_W   = 7,
  parameter int TIMEOUT = 63,
  parameter int TO_W    = 6
) (
  input  logic               Clock,
  input  logic               nReset,
  input  logic               Refresh,
  input  logic [BAR_W-1:0]   NumBars,
  input  logic [RGB_W-1:0]   ColorL,
  input  logic [RGB_W-1:0]   ColorR,
  input  logic               GradationEn,
  input  logic               SingleReq,
  input  logic               SingleCh,
  input  logic [BAR_W-1:0]   SingleBar,
  output logic               SingleAck,
  output logic               BcStart,
  output logic [BAR_W-1:0]   BcBar,
  output logic [RGB_W-1:0]   BcInColor,
  output logic               BcGradEn,
  input  logic               BcEnd,
  input  logic [RGB_W-1:0]   BcColor,
  output logic               WrEn,
  output logic [BAR_W:0]     WrAddr,
  output logic [RGB_W-1:0]   WrData,
  output logic               Busy,
  output logic               Done,
  output logic               Err
);

  state_t             state, state_d;
  logic               pend;
  logic               ch;
  logic               mode_ref;
  logic               last_ref;
  logic               err_q;
  logic [BAR_W-1:0]   bar;
  logic [BAR_W-1:0]   num_q;
  logic [TO_W-1:0]    to_cnt;
  logic [RGB_W-1:0]   in_color_q;
  logic [RGB_W-1:0]   wr_data_q;
  logic               grad_q;

  logic               ref_req;
  logic               launch_ref;
  logic               launch_single;
  logic               timeout_hit;
  logic               last_bar;
  logic [RGB_W-1:0]   issue_color;

  assign ref_req     = Refresh | pend;
  assign issue_color = ch ? ColorR : ColorL;
  assign last_bar    = (bar == num_q - 1'b1);
  // BcEnd on the final count still counts as success, hence the !BcEnd term.
  assign timeout_hit = (state == ST_WAIT) && !BcEnd && (to_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d       = state;
    launch_ref    = 1'b0;
    launch_single = 1'b0;
    case (state)
      ST_IDLE: begin
        // Alternate priority when both sources wait, so neither starves.
        if (ref_req && (!SingleReq || !last_ref)) begin
          launch_ref = 1'b1;
          state_d    = (NumBars == '0) ? ST_DONE : ST_ISSUE;
        end else if (SingleReq) begin
          launch_single = 1'b1;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (BcEnd)            state_d = ST_WRITE;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_WRITE: begin
        if (!mode_ref)                  state_d = ST_IDLE;
        else if (!last_bar || ch == CH_L) state_d = ST_ISSUE;
        else                            state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state      <= ST_IDLE;
      pend       <= 1'b0;
      ch         <= CH_L;
      bar        <= '0;
      num_q      <= '0;
      mode_ref   <= 1'b0;
      last_ref   <= 1'b0;
      err_q      <= 1'b0;
      to_cnt     <= '0;
      in_color_q <= '0;
      grad_q     <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state <= state_d;
      pend  <= (pend | Refresh) & ~launch_ref;
      if (state != ST_IDLE && state_d == ST_IDLE) last_ref <= mode_ref;
      case (state)
        ST_IDLE: begin
          if (launch_ref) begin
            num_q    <= NumBars;
            ch       <= CH_L;
            bar      <= '0;
            mode_ref <= 1'b1;
          end else if (launch_single) begin
            ch       <= SingleCh;
            bar      <= SingleBar;
            mode_ref <= 1'b0;
          end
        end
        ST_ISSUE: begin
          // BarColor samples its inputs late, so freeze them for the whole WAIT.
          in_color_q <= issue_color;
          grad_q     <= GradationEn;
          to_cnt     <= '0;
        end
        ST_WAIT: begin
          if (BcEnd) begin
            wr_data_q <= BcColor;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (timeout_hit) err_q <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (mode_ref) begin
            if (!last_bar) begin
              bar <= bar + 1'b1;
            end else if (ch == CH_L) begin
              ch  <= CH_R;
              bar <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign BcStart   = (state == ST_ISSUE);
  assign BcBar     = bar;
  assign BcInColor = (state == ST_ISSUE) ? issue_color : in_color_q;
  assign BcGradEn  = (state == ST_ISSUE) ? GradationEn : grad_q;
  assign WrEn      = (state == ST_WRITE);
  assign WrAddr    = {ch, bar};
  assign WrData    = wr_data_q;
  assign Busy      = (state != ST_IDLE);
  assign Done      = (state == ST_DONE);
  assign Err       = err_q;
  assign SingleAck = !mode_ref && ((state == ST_WRITE) || timeout_hit);

  a_single_held: assert property (@(posedge Clock) disable iff (!nReset)
    (!mode_ref && (state == ST_ISSUE || (state == ST_WAIT && !timeout_hit))) |-> SingleReq);

endmodule

// File: tb/tb_bar_color_sched.sv
// Randomized scoreboard bench for bar_color_sched with a behavioural BarColor model.
module tb_bar_color_sched;

  localparam int K_WR   = 0;
  localparam int K_ACK  = 1;
  localparam int K_DONE = 2;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        Refresh = 1'b0;
  logic [6:0]  NumBars = 7'd0;
  logic [14:0] ColorL = 15'h7C00;
  logic [14:0] ColorR = 15'h001F;
  logic        GradationEn = 1'b0;
  logic        SingleReq = 1'b0;
  logic        SingleCh = 1'b0;
  logic [6:0]  SingleBar = 7'd0;
  logic        SingleAck;
  logic        BcStart;
  logic [6:0]  BcBar;
  logic [14:0] BcInColor;
  logic        BcGradEn;
  logic        BcEnd = 1'b0;
  logic [14:0] BcColor = 15'd0;
  logic        WrEn;
  logic [7:0]  WrAddr;
  logic [14:0] WrData;
  logic        Busy;
  logic        Done;
  logic        Err;

  typedef struct {
    int kind;
    int addr;
    int data;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad = 0;
  int  n_start = 0;
  int  n_wr = 0;
  int  bc_lat = 5;
  bit  bc_dead = 1'b0;
  int  bc_pend = 0;

  bar_color_sched dut (
    .Clock(Clock), .nReset(nReset), .Refresh(Refresh), .NumBars(NumBars),
    .ColorL(ColorL), .ColorR(ColorR), .GradationEn(GradationEn),
    .SingleReq(SingleReq), .SingleCh(SingleCh), .SingleBar(SingleBar),
    .SingleAck(SingleAck), .BcStart(BcStart), .BcBar(BcBar),
    .BcInColor(BcInColor), .BcGradEn(BcGradEn), .BcEnd(BcEnd), .BcColor(BcColor),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .Busy(Busy), .Done(Done), .Err(Err)
  );

  initial forever #5 Clock = ~Clock;

  function automatic logic [14:0] bc_fn(logic [14:0] c, logic [6:0] b, logic g);
    return g ? c + 15'(b) : c ^ {b, 8'h00};
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(int k, int a, int d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  // Reference: a refresh writes every bar of L, then every bar of R, then Done.
  task automatic push_refresh(int n, logic [14:0] cl, logic [14:0] cr, logic g);
    for (int c = 0; c < 2; c++)
      for (int b = 0; b < n; b++)
        push_ev(K_WR, c * 128 + b, int'(bc_fn(c == 1 ? cr : cl, 7'(b), g)));
    push_ev(K_DONE, 0, 0);
  endtask

  task automatic expect_ev(int k, int a, int d);
    ev_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d addr=%0d data=%0h expected none", k, a, d);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.addr != a || e.data != d) begin
        bad++;
        $display("FAIL scoreboard: got kind=%0d addr=%0d data=%0h expected kind=%0d addr=%0d data=%0h",
                 k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // BarColor model: End arrives bc_lat cycles after Start; inputs sampled late.
  initial forever begin
    @(posedge Clock);
    #1;
    BcEnd = 1'b0;
    BcColor = 15'($urandom);
    if (!nReset) begin
      bc_pend = 0;
    end else begin
      if (bc_pend > 0) begin
        bc_pend--;
        if (bc_pend == 0) begin
          BcEnd = 1'b1;
          BcColor = bc_fn(BcInColor, BcBar, BcGradEn);
        end
      end
      if (BcStart && !bc_dead) bc_pend = bc_lat;
    end
  end

  initial forever begin
    @(negedge Clock);
    if (nReset) begin
      if (BcStart) n_start++;
      if (WrEn) begin
        n_wr++;
        expect_ev(K_WR, int'(WrAddr), int'(WrData));
      end
      if (SingleAck) expect_ev(K_ACK, 0, 0);
      if (Done) expect_ev(K_DONE, 0, 0);
    end
  end

  task automatic tick();
    @(negedge Clock);
    if (SingleAck) SingleReq = 1'b0;
  endtask

  task automatic pulse_refresh();
    Refresh = 1'b1;
    tick();
    Refresh = 1'b0;
  endtask

  task automatic wait_idle(string name, int budget);
    int run = 0;
    int n = 0;
    while (run < 3 && n < budget) begin
      tick();
      n++;
      run = Busy ? 0 : run + 1;
    end
    total++;
    if (run < 3) begin
      bad++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
    end
    check({name, "_sb_drained"}, sb.size(), 0);
  endtask

  initial begin
    int n, s0, w0, lo, cyc;
    logic g;

    #3;
    check("rst_busy", int'(Busy), 0);
    check("rst_err", int'(Err), 0);
    check("rst_bcstart", int'(BcStart), 0);
    check("rst_incolor", int'(BcInColor), 0);
    check("rst_wr", int'({WrEn, WrAddr, WrData}), 0);
    check("rst_misc", int'({Done, SingleAck, BcBar, BcGradEn}), 0);
    @(negedge Clock);
    @(negedge Clock);
    nReset = 1'b1;
    tick();

    // Full refresh, 3 bars, red/blue base colours
    NumBars = 7'd3; ColorL = 15'h7C00; ColorR = 15'h001F;
    g = 1'($urandom_range(0, 1)); GradationEn = g; bc_lat = 5;
    w0 = n_wr;
    push_refresh(3, ColorL, ColorR, g);
    pulse_refresh();
    check("refresh_latency", int'(BcStart), 1);
    lo = 0; n = 0;
    while (!Done && n < 200) begin
      if (!Busy) lo++;
      tick();
      n++;
    end
    check("busy_throughout", lo, 0);
    check("done_seen", int'(Done), 1);
    wait_idle("refresh3", 50);
    check("refresh3_writes", n_wr - w0, 6);

    // NumBars = 0: Done only
    s0 = n_start; w0 = n_wr;
    NumBars = 7'd0;
    push_ev(K_DONE, 0, 0);
    pulse_refresh();
    check("nb0_done_next", int'(Done), 1);
    wait_idle("nb0", 20);
    check("nb0_no_start", n_start - s0, 0);
    check("nb0_no_write", n_wr - w0, 0);

    // Lone single entry
    bc_lat = $urandom_range(1, 8);
    ColorL = 15'($urandom); g = 1'($urandom_range(0, 1)); GradationEn = g;
    SingleCh = 1'b0; SingleBar = 7'($urandom_range(0, 127));
    push_ev(K_WR, int'(SingleBar), int'(bc_fn(ColorL, SingleBar, g)));
    push_ev(K_ACK, 0, 0);
    SingleReq = 1'b1;
    wait_idle("single_alone", 50);
    check("single_req_dropped", int'(SingleReq), 0);

    // Refresh and single together, then a refresh requested mid-flight
    n = $urandom_range(2, 4); bc_lat = $urandom_range(3, 6);
    NumBars = 7'(n); ColorL = 15'($urandom); ColorR = 15'($urandom);
    g = 1'($urandom_range(0, 1)); GradationEn = g;
    push_refresh(n, ColorL, ColorR, g);
    push_ev(K_WR, 128 + 5, int'(bc_fn(ColorR, 7'd5, g)));
    push_ev(K_ACK, 0, 0);
    push_refresh(n, ColorL, ColorR, g);
    SingleCh = 1'b1; SingleBar = 7'd5; SingleReq = 1'b1;
    pulse_refresh();
    repeat (8) tick();
    pulse_refresh();
    wait_idle("arbitration", 1000);

    // Three extra pulses while busy collapse into one more refresh
    n = $urandom_range(2, 4); bc_lat = $urandom_range(2, 5);
    NumBars = 7'(n); ColorL = 15'($urandom); ColorR = 15'($urandom);
    g = 1'($urandom_range(0, 1)); GradationEn = g;
    w0 = n_wr;
    push_refresh(n, ColorL, ColorR, g);
    push_refresh(n, ColorL, ColorR, g);
    pulse_refresh();
    repeat (3) begin
      repeat (3) tick();
      pulse_refresh();
    end
    wait_idle("pending_one_deep", 1000);
    check("pending_writes", n_wr - w0, 4 * n);

    // BarColor never answers
    bc_dead = 1'b1; NumBars = 7'd2;
    w0 = n_wr;
    pulse_refresh();
    cyc = 0;
    while (Busy && cyc < 200) begin
      cyc++;
      tick();
    end
    check("timeout_cycles", cyc, 64);
    check("timeout_err", int'(Err), 1);
    wait_idle("timeout_refresh", 20);
    check("timeout_no_write", n_wr - w0, 0);
    push_ev(K_ACK, 0, 0);
    SingleCh = 1'b0; SingleBar = 7'd7; SingleReq = 1'b1;
    wait_idle("timeout_single", 200);
    check("err_sticky", int'(Err), 1);
    bc_dead = 1'b0;

    // Reset in the middle of WAIT, with a refresh pending
    bc_lat = 30; NumBars = 7'd3;
    pulse_refresh();
    repeat (5) tick();
    pulse_refresh();
    pulse_refresh();
    #2 nReset = 1'b0;
    #1;
    check("midrst_busy", int'(Busy), 0);
    check("midrst_err", int'(Err), 0);
    check("midrst_outs", int'({BcStart, WrEn, Done, SingleAck, BcGradEn}), 0);
    check("midrst_incolor", int'(BcInColor), 0);
    @(negedge Clock);
    nReset = 1'b1;
    repeat (10) tick();
    check("midrst_pending_cleared", int'(Busy), 0);
    n = 2; bc_lat = 3; NumBars = 7'd2;
    ColorL = 15'($urandom); ColorR = 15'($urandom);
    g = 1'($urandom_range(0, 1)); GradationEn = g;
    push_refresh(n, ColorL, ColorR, g);
    pulse_refresh();
    wait_idle("post_reset_refresh", 200);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
